ice40_iserdes_aligner: RTL and testbench
========================================

Name: ice40_iserdes_aligner

Overview:
Parametrised multi-lane deserialiser with automatic word alignment. It runs in a single clock domain and sits after the IOB/DDR capture stage, which delivers one bit per lane per input strobe. It assembles WIDTH-bit words per lane and uses a training-pattern FSM on lane 0 to pick the bit offset (slip position). All lanes share that slip position, so multi-lane links stay word-coherent.

Parameters:
WIDTH, 8, word width per lane in bits; legal range 2..16.
LANES, 1, number of serial lanes; legal range 1..8.
SYNC_PATTERN, 8'hB8, WIDTH-bit training word matched on lane 0.
LOCK_COUNT, 4, consecutive matching words required to declare lock; legal range 1..15.
SW (localparam), max($clog2(WIDTH),1), width of slip_pos.

Ports:
clk  in  1  single clock for the whole block.
rst  in  1  asynchronous, active-high reset.
in_data  in  LANES  one new serial bit per lane; bit i belongs to lane i.
in_stb  in  1  in_data is valid this cycle.
align_en  in  1  enables the alignment FSM; when low, the FSM and slip_pos freeze.
relock  in  1  single-cycle pulse that forces a return to HUNT.
out_data  out  LANES*WIDTH  lane i word in [i*WIDTH +: WIDTH]; first-received bit sits at the MSB.
out_stb  out  1  single-cycle pulse marking a new word on out_data.
locked  out  1  alignment achieved.
slip_pos  out  SW  current bit offset, 0..WIDTH-1.

Behaviour:
- Reset: all history registers, the bit counter, out_data, out_stb, locked, slip_pos and the skip flag are cleared to 0; the FSM goes to HUNT. Reset takes effect immediately when asserted mid-word or mid-lock. After release, the first word needs a full WIDTH strobes.
- History: each lane keeps a (2*WIDTH-1)-bit shift register. On in_stb the register shifts left and the new bit enters bit 0. Nothing changes on cycles without in_stb.
- Bit counter: counts 0..WIDTH-1 on in_stb and wraps. The strobe that occurs at count WIDTH-1 is the word-completing strobe.
- Word output:
  - On the cycle after a word-completing strobe, out_stb=1 and each lane slice of out_data = post-shift history[slip_pos+WIDTH-1 : slip_pos]. Latency is therefore 1 cycle.
  - out_data holds its value between strobes; out_stb is 0 otherwise.
  - Words are emitted whether or not the block is locked; consumers gate on locked.
- FSM: states HUNT, CHECK, LOCKED. It evaluates only the lane-0 word, only on out_stb cycles, and only when align_en=1.
  - HUNT, skip flag set: clear skip; no compare.
  - HUNT, word == SYNC_PATTERN: go to CHECK, match_cnt=1. If LOCK_COUNT==1, go directly to LOCKED.
  - HUNT, mismatch: slip_pos increments, wrapping from WIDTH-1 to 0; set skip. The word following a slip is transient and is not compared.
  - CHECK, match: match_cnt increments. When match_cnt reaches LOCK_COUNT, go to LOCKED and assert locked in the same cycle as that out_stb.
  - CHECK, mismatch: go to HUNT, slip as above, set skip, match_cnt=0.
  - LOCKED: no compares; slip_pos is held.
- align_en=0: state, match_cnt, skip and slip_pos are all frozen, but words keep flowing.
- relock=1:
  - Next cycle: state=HUNT, locked=0, match_cnt=0, skip=0; slip_pos is retained.
  - relock takes priority over any FSM evaluation in the same cycle and acts even when align_en=0.
- A slip does not disturb the bit counter; word boundaries stay on the counter cadence.

Test Plan:
1. WIDTH=8, LANES=2, LOCK_COUNT=4, align_en=1. Stimulus: lane 0 gets five 0 bits then repeating 0xB8; lane 1 gets five 0 bits then repeating 0x3C, strobe every cycle. Required: slips to 1, 2, 3 at words 1, 3, 5; words 2, 4, 6 skipped; matches at words 7..10. locked=1 with slip_pos=3 on the out_stb of word 10; lane 1 reads 0x3C from word 7 onward.
2. Locked as in test 1, then a relock pulse while the stream continues unchanged. Required: locked=0 on the next cycle; slip_pos stays 3. The next word matches and locked=1 again four words later.
3. Stream of repeating 0xFF, never matching. Required: slip_pos steps 0→1→…→7→0 every two words; locked stays 0 indefinitely.
4. Stimulus: align_en=0 from reset, with the stream from test 1. Required: slip_pos=0 and state HUNT for 20 words; out_stb still pulses every 8 strobes. Raising align_en then gives the test-1 sequence.
5. in_stb asserted every third cycle with the stream from test 1. Required: the same slip/lock sequence; out_stb spaced 24 cycles apart, each exactly 1 cycle after the 8th strobe.
6. rst asserted mid-word while locked. Required: all outputs are 0 immediately. After release, the first out_stb follows exactly 8 strobes and the lock sequence restarts from slip_pos=0.

Source files
------------

// File: rtl/ice40_iserdes_aligner.sv
// Multi-lane deserialiser with lane-0 training-pattern word alignment.
// Ports: clk, rst (async high), in_data/in_stb serial bits in,
//   align_en/relock alignment control, out_data/out_stb words out,
//   locked alignment flag, slip_pos shared bit offset.
module ice40_iserdes_aligner #(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(8'hB8),
  parameter int LOCK_COUNT = 4,
  localparam int SW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_data,
  input  logic                   in_stb,
  input  logic                   align_en,
  input  logic                   relock,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_stb,
  output logic                   locked,
  output logic [SW-1:0]          slip_pos
);

  localparam int HL = 2*WIDTH-1;
  localparam int HW = $clog2(HL);
  localparam logic [SW-1:0] LAST = SW'(WIDTH-1);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKD
  } state_t;

  state_t state, state_n;
  logic [3:0] match_cnt, cnt_n;
  logic skip, skip_n;
  logic [SW-1:0] slip_n;
  logic [SW-1:0] slip_inc;

  logic [HL-1:0] hist [LANES];
  logic [HL-1:0] hist_nxt [LANES];
  logic [LANES*WIDTH-1:0] word_nxt;
  logic [SW-1:0] bit_cnt;
  logic [HW-1:0] base;
  logic word_done;
  logic hit;

  assign base = HW'(slip_pos);
  assign word_done = in_stb && (bit_cnt == LAST);

  // The word is extracted from the post-shift history so the
  // completing bit is already part of it.
  always_comb begin
    word_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      hist_nxt[l] = {hist[l][HL-2:0], in_data[l]};
      word_nxt[l*WIDTH +: WIDTH] = hist_nxt[l][base +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) hist[l] <= '0;
      bit_cnt <= '0;
    end else if (in_stb) begin
      for (int l = 0; l < LANES; l++) hist[l] <= hist_nxt[l];
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_stb  <= 1'b0;
    end else begin
      out_stb <= word_done;
      if (word_done) out_data <= word_nxt;
    end
  end

  // The FSM judges the word as it is loaded into out_data, so the
  // state (and locked) change in the same cycle that out_stb rises.
  assign hit = (word_nxt[WIDTH-1:0] == SYNC_PATTERN);
  assign slip_inc = (slip_pos == LAST) ? '0 : slip_pos + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = match_cnt;
    skip_n  = skip;
    slip_n  = slip_pos;
    if (relock) begin
      state_n = HUNT;
      cnt_n   = '0;
      skip_n  = 1'b0;
    end else if (align_en && word_done) begin
      unique case (state)
        HUNT: begin
          if (skip) begin
            skip_n = 1'b0;
          end else if (hit) begin
            cnt_n   = 4'd1;
            state_n = (LOCK_COUNT == 1) ? LOCKD : CHECK;
          end else begin
            slip_n = slip_inc;
            skip_n = 1'b1;
          end
        end
        CHECK: begin
          if (hit) begin
            cnt_n = match_cnt + 4'd1;
            if (cnt_n == LC) state_n = LOCKD;
          end else begin
            state_n = HUNT;
            slip_n  = slip_inc;
            skip_n  = 1'b1;
            cnt_n   = '0;
          end
        end
        LOCKD: begin
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      match_cnt <= '0;
      skip      <= 1'b0;
      slip_pos  <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= cnt_n;
      skip      <= skip_n;
      slip_pos  <= slip_n;
    end
  end

  assign locked = (state == LOCKD);

endmodule

// File: tb/tb_ice40_iserdes_aligner.sv
// Directed bench for ice40_iserdes_aligner (WIDTH=8, LANES=2).
// Each scenario task drives a serial stream and checks words inline.
module tb_ice40_iserdes_aligner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in_data = '0;
  logic in_stb = 1'b0;
  logic align_en = 1'b0;
  logic relock = 1'b0;
  logic [15:0] out_data;
  logic out_stb;
  logic locked;
  logic [2:0] slip_pos;

  ice40_iserdes_aligner #(
    .WIDTH(8),
    .LANES(2),
    .SYNC_PATTERN(8'hB8),
    .LOCK_COUNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_stb(in_stb),
    .align_en(align_en),
    .relock(relock),
    .out_data(out_data),
    .out_stb(out_stb),
    .locked(locked),
    .slip_pos(slip_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s = 0;
  int lead = 5;
  int gap = 0;
  logic [7:0] pat0 = 8'hB8;
  logic [7:0] pat1 = 8'h3C;

  // Expected lane-0 words / slip for the five-zero-lead B8 stream.
  int exp_slip [11] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
  logic [7:0] exp_w0 [11] = '{8'h00, 8'h05, 8'h00, 8'hE2, 8'h00,
                              8'h71, 8'h00, 8'hB8, 8'hB8, 8'hB8, 8'hB8};
  bit chk_w [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic sb(input logic [7:0] p, input int idx);
    if (idx < lead) return 1'b0;
    return p[7 - ((idx - lead) % 8)];
  endfunction

  task automatic send_bit();
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data = {sb(pat1, s), sb(pat0, s)};
    in_stb = 1'b1;
    @(posedge clk);
    #1;
    in_stb = 1'b0;
    s++;
  endtask

  task automatic send_word();
    repeat (8) send_bit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_stb = 1'b0;
    relock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    s = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_data, out_stb, locked, slip_pos} !== '0)
      $display("FAIL reset_hold: got %h/%b/%b/%0d want 0",
               out_data, out_stb, locked, slip_pos);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_data, out_stb, locked, slip_pos} !== '0)
      $display("FAIL reset_release: got %h/%b/%b/%0d want 0",
               out_data, out_stb, locked, slip_pos);
  endtask

  task automatic test_lock();
    do_reset();
    align_en = 1'b1;
    pat0 = 8'hB8;
    pat1 = 8'h3C;
    lead = 5;
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      send_word();
      n_cmp++;
      if (out_stb !== 1'b1) begin
        n_bad++;
        $display("FAIL lock_stb w%0d: got %b want 1", k, out_stb);
      end
      n_cmp++;
      if (slip_pos !== 3'(exp_slip[k])) begin
        n_bad++;
        $display("FAIL lock_slip w%0d: got %0d want %0d",
                 k, slip_pos, exp_slip[k]);
      end
      n_cmp++;
      if (locked !== (k == 10)) begin
        n_bad++;
        $display("FAIL lock_locked w%0d: got %b want %b",
                 k, locked, k == 10);
      end
      if (chk_w[k]) begin
        n_cmp++;
        if (out_data[7:0] !== exp_w0[k]) begin
          n_bad++;
          $display("FAIL lock_w0 w%0d: got %h want %h",
                   k, out_data[7:0], exp_w0[k]);
        end
      end
      if (k >= 7) begin
        n_cmp++;
        if (out_data[15:8] !== 8'h3C) begin
          n_bad++;
          $display("FAIL lock_w1 w%0d: got %h want 3c",
                   k, out_data[15:8]);
        end
      end
    end
  endtask

  task automatic test_relock();
    relock = 1'b1;
    send_bit();
    relock = 1'b0;
    n_cmp++;
    if (locked !== 1'b0 || slip_pos !== 3'd3) begin
      n_bad++;
      $display("FAIL relock_drop: got %b/%0d want 0/3", locked, slip_pos);
    end
    repeat (7) send_bit();
    for (int k = 11; k <= 14; k++) begin
      if (k > 11) send_word();
      n_cmp++;
      if (out_stb !== 1'b1 || out_data !== 16'h3CB8) begin
        n_bad++;
        $display("FAIL relock_word w%0d: got %b/%h want 1/3cb8",
                 k, out_stb, out_data);
      end
      n_cmp++;
      if (locked !== (k == 14) || slip_pos !== 3'd3) begin
        n_bad++;
        $display("FAIL relock_lock w%0d: got %b/%0d want %b/3",
                 k, locked, slip_pos, k == 14);
      end
    end
  endtask

  task automatic test_no_match();
    do_reset();
    align_en = 1'b1;
    pat0 = 8'hFF;
    pat1 = 8'hFF;
    lead = 0;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      send_word();
      n_cmp++;
      if (slip_pos !== 3'(((k + 1) / 2) % 8)) begin
        n_bad++;
        $display("FAIL nomatch_slip w%0d: got %0d want %0d",
                 k, slip_pos, ((k + 1) / 2) % 8);
      end
      n_cmp++;
      if (locked !== 1'b0 || out_data[7:0] !== 8'hFF) begin
        n_bad++;
        $display("FAIL nomatch_word w%0d: got %b/%h want 0/ff",
                 k, locked, out_data[7:0]);
      end
    end
  endtask

  task automatic test_align_en();
    do_reset();
    align_en = 1'b0;
    pat0 = 8'hB8;
    pat1 = 8'h3C;
    lead = 5;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      send_word();
      n_cmp++;
      if (out_stb !== 1'b1 || slip_pos !== 3'd0 || locked !== 1'b0) begin
        n_bad++;
        $display("FAIL frozen w%0d: got %b/%0d/%b want 1/0/0",
                 k, out_stb, slip_pos, locked);
      end
    end
    align_en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      send_word();
      n_cmp++;
      if (slip_pos !== 3'(exp_slip[j]) || locked !== (j == 10)) begin
        n_bad++;
        $display("FAIL enable_seq w%0d: got %0d/%b want %0d/%b",
                 j + 20, slip_pos, locked, exp_slip[j], j == 10);
      end
      if (j == 1 || chk_w[j]) begin
        n_cmp++;
        if (out_data[7:0] !== ((j == 1) ? 8'hC5 : exp_w0[j])) begin
          n_bad++;
          $display("FAIL enable_w0 w%0d: got %h want %h", j + 20,
                   out_data[7:0], (j == 1) ? 8'hC5 : exp_w0[j]);
        end
      end
    end
  endtask

  task automatic test_sparse();
    int last;
    last = 0;
    do_reset();
    align_en = 1'b1;
    lead = 5;
    gap = 2;
    for (int k = 1; k <= 10; k++) begin
      send_word();
      n_cmp++;
      if (out_stb !== 1'b1 || slip_pos !== 3'(exp_slip[k])) begin
        n_bad++;
        $display("FAIL sparse_slip w%0d: got %b/%0d want 1/%0d",
                 k, out_stb, slip_pos, exp_slip[k]);
      end
      n_cmp++;
      if (locked !== (k == 10)) begin
        n_bad++;
        $display("FAIL sparse_lock w%0d: got %b want %b",
                 k, locked, k == 10);
      end
      if (chk_w[k]) begin
        n_cmp++;
        if (out_data[7:0] !== exp_w0[k]) begin
          n_bad++;
          $display("FAIL sparse_w0 w%0d: got %h want %h",
                   k, out_data[7:0], exp_w0[k]);
        end
      end
      if (k > 1) begin
        n_cmp++;
        if (cyc - last !== 24) begin
          n_bad++;
          $display("FAIL sparse_gap w%0d: got %0d want 24",
                   k, cyc - last);
        end
      end
      last = cyc;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_stb !== 1'b0 || out_data !== 16'h3CB8) begin
      n_bad++;
      $display("FAIL sparse_hold: got %b/%h want 0/3cb8",
               out_stb, out_data);
    end
  endtask

  task automatic test_mid_reset();
    gap = 0;
    repeat (3) send_bit();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_data, out_stb, locked, slip_pos} !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got %h/%b/%b/%0d want 0",
               out_data, out_stb, locked, slip_pos);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s = 0;
    repeat (7) send_bit();
    n_cmp++;
    if (out_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_early_stb: got %b want 0", out_stb);
    end
    send_bit();
    n_cmp++;
    if (out_stb !== 1'b1 || out_data[7:0] !== 8'h05 ||
        slip_pos !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_first_word: got %b/%h/%0d want 1/05/1",
               out_stb, out_data[7:0], slip_pos);
    end
    for (int k = 2; k <= 10; k++) begin
      send_word();
      n_cmp++;
      if (slip_pos !== 3'(exp_slip[k]) || locked !== (k == 10)) begin
        n_bad++;
        $display("FAIL rst_relock w%0d: got %0d/%b want %0d/%b",
                 k, slip_pos, locked, exp_slip[k], k == 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_relock();
    test_no_match();
    test_align_en();
    test_sparse();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
